// File: rtl/mtr_pkg.sv
// Shared constants and the speed-to-duty mapping for the motor drive stage.
package mtr_pkg;

    localparam int               CNT_W          = 11;
    localparam int               PERIOD         = 2048;
    localparam logic [CNT_W-1:0] DUTY_MID       = 11'h400;
    localparam logic [CNT_W-1:0] CNT_MAX        = 11'h7FF;
    localparam int               NONOVERLAP_DEF = 32;

    // Offset binary: adding mid-scale to a two's complement speed flips its MSB.
    function automatic logic [CNT_W-1:0] spd_to_duty(input logic signed [CNT_W-1:0] spd);
        return logic'(~spd[CNT_W-1]) ? {1'b1, spd[CNT_W-2:0]} : {1'b0, spd[CNT_W-2:0]};
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_chan.sv
// One H-bridge channel: double-buffered duty and complementary PWM pair with dead time.
module pwm_chan
    import mtr_pkg::*;
#(
    parameter int NONOVERLAP = NONOVERLAP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] spd,
    input  logic             load,
    output logic             pwm1,
    output logic             pwm2
);

    localparam logic [CNT_W-1:0] SET1_AT = CNT_W'(NONOVERLAP);
    localparam logic [CNT_W:0]   NOV_EXT = (CNT_W+1)'(NONOVERLAP);

    logic signed [CNT_W-1:0] spd_s;
    logic [CNT_W-1:0]        duty_sh_d, duty_sh_q;
    logic [CNT_W:0]          set2_at;
    logic                    pwm1_d, pwm1_q;
    logic                    pwm2_d, pwm2_q;

    always_comb begin
        spd_s     = spd;
        duty_sh_d = duty_sh_q;
        if (load) begin
            duty_sh_d = spd_to_duty(spd_s);
        end

        // Clear wins so a duty at or below the dead time never raises PWM1.
        pwm1_d = pwm1_q;
        if (cnt >= duty_sh_q) begin
            pwm1_d = 1'b0;
        end else if (cnt == SET1_AT) begin
            pwm1_d = 1'b1;
        end

        // Set point kept 12 bits wide so a sum past 2047 simply never matches.
        set2_at = {1'b0, duty_sh_q} + NOV_EXT;
        pwm2_d  = pwm2_q;
        if (load) begin
            pwm2_d = 1'b0;
        end else if ({1'b0, cnt} == set2_at) begin
            pwm2_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_q <= DUTY_MID;
            pwm1_q    <= 1'b0;
            pwm2_q    <= 1'b0;
        end else begin
            duty_sh_q <= duty_sh_d;
            pwm1_q    <= pwm1_d;
            pwm2_q    <= pwm2_d;
        end
    end

    assign pwm1 = pwm1_q;
    assign pwm2 = pwm2_q;

endmodule

// File: rtl/mtr_drv.sv
// Motor drive top: shared period counter, period sync pulse and two PWM channels.
module mtr_drv
    import mtr_pkg::*;
#(
    parameter int NONOVERLAP = NONOVERLAP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  lft_spd,
    input  logic [CNT_W-1:0]  rght_spd,
    output logic              lftPWM1,
    output logic              lftPWM2,
    output logic              rghtPWM1,
    output logic              rghtPWM2,
    output logic              PWM_synch
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             synch_d, synch_q;
    logic             load;

    always_comb begin
        load    = (cnt_q == CNT_MAX);
        cnt_d   = cnt_q + 1'b1;
        synch_d = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            synch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            synch_q <= synch_d;
        end
    end

    assign PWM_synch = synch_q;

    pwm_chan #(.NONOVERLAP(NONOVERLAP)) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt_q),
        .spd   (lft_spd),
        .load  (load),
        .pwm1  (lftPWM1),
        .pwm2  (lftPWM2)
    );

    pwm_chan #(.NONOVERLAP(NONOVERLAP)) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt_q),
        .spd   (rght_spd),
        .load  (load),
        .pwm1  (rghtPWM1),
        .pwm2  (rghtPWM2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboard bench for mtr_drv: per-period high counts, sync spacing and dead time.
module tb_mtr_drv;

    localparam int NOV = 32;
    localparam int PER = 2048;

    typedef struct {
        int l1;
        int l2;
        int r1;
        int r2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    bit   mon_en = 1'b0;
    int   ncyc;
    int   samp, since;
    int   acc_l1, acc_l2, acc_r1, acc_r2;
    int   viol_l, viol_r;
    int   hi_l1, hi_l2, hi_r1, hi_r2;
    bit   prv_l1, prv_l2, prv_r1, prv_r2;

    mtr_drv #(.NONOVERLAP(NOV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .lftPWM1   (lftPWM1),
        .lftPWM2   (lftPWM2),
        .rghtPWM1  (rghtPWM1),
        .rghtPWM2  (rghtPWM2),
        .PWM_synch (PWM_synch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: one period's high-cycle counts from the speed held at the load instant.
    function automatic exp_t predict(input int l_spd, input int r_spd);
        exp_t e;
        int   dl, dr;
        dl   = l_spd + 1024;
        dr   = r_spd + 1024;
        e.l1 = (dl > NOV) ? dl - NOV : 0;
        e.l2 = (dl + NOV < 2047) ? 2047 - dl - NOV : 0;
        e.r1 = (dr > NOV) ? dr - NOV : 0;
        e.r2 = (dr + NOV < 2047) ? 2047 - dr - NOV : 0;
        return e;
    endfunction

    function automatic int sval(input logic [10:0] v);
        return int'($signed(v));
    endfunction

    // Model: the speed present at the end of a period governs the next one.
    always @(posedge clk) begin
        if (mon_en) begin
            ncyc++;
            if (ncyc % PER == 0) exp_q.push_back(predict(sval(lft_spd), sval(rght_spd)));
        end
    end

    // Monitor: accumulates outputs and scores a period whenever PWM_synch marks its end.
    always @(negedge clk) begin
        if (mon_en) begin
            if (PWM_synch) begin
                exp_t e;
                chk("synch_interval", since, PER);
                if (exp_q.size() == 0) begin
                    chk("exp_queue_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("lft_pwm1_hi", acc_l1, e.l1);
                    chk("lft_pwm2_hi", acc_l2, e.l2);
                    chk("rght_pwm1_hi", acc_r1, e.r1);
                    chk("rght_pwm2_hi", acc_r2, e.r2);
                end
                chk("lft_overlap_deadtime", viol_l, 0);
                chk("rght_overlap_deadtime", viol_r, 0);
                acc_l1 = 0; acc_l2 = 0; acc_r1 = 0; acc_r2 = 0;
                viol_l = 0; viol_r = 0;
                since  = 0;
            end
            since++;
            if (since == PER + 2) chk("synch_timeout", since, PER);

            acc_l1 += int'(lftPWM1);
            acc_l2 += int'(lftPWM2);
            acc_r1 += int'(rghtPWM1);
            acc_r2 += int'(rghtPWM2);

            if (lftPWM1 && lftPWM2) viol_l++;
            if (rghtPWM1 && rghtPWM2) viol_r++;
            if (lftPWM1 && !prv_l1 && (samp - hi_l2 - 1) < NOV) viol_l++;
            if (lftPWM2 && !prv_l2 && (samp - hi_l1 - 1) < NOV) viol_l++;
            if (rghtPWM1 && !prv_r1 && (samp - hi_r2 - 1) < NOV) viol_r++;
            if (rghtPWM2 && !prv_r2 && (samp - hi_r1 - 1) < NOV) viol_r++;

            if (lftPWM1)  hi_l1 = samp;
            if (lftPWM2)  hi_l2 = samp;
            if (rghtPWM1) hi_r1 = samp;
            if (rghtPWM2) hi_r2 = samp;
            prv_l1 = lftPWM1; prv_l2 = lftPWM2;
            prv_r1 = rghtPWM1; prv_r2 = rghtPWM2;
            samp++;
        end
    end

    task automatic chk_all_low(input string tag);
        chk({tag, "_lftPWM1"}, int'(lftPWM1), 0);
        chk({tag, "_lftPWM2"}, int'(lftPWM2), 0);
        chk({tag, "_rghtPWM1"}, int'(rghtPWM1), 0);
        chk({tag, "_rghtPWM2"}, int'(rghtPWM2), 0);
        chk({tag, "_PWM_synch"}, int'(PWM_synch), 0);
    endtask

    // Release just after a rising edge so the first negedge sample is the cnt==0 cycle.
    task automatic release_rst();
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_q.push_back(predict(0, 0));
        ncyc  = 0;
        samp  = 0;
        since = 0;
        acc_l1 = 0; acc_l2 = 0; acc_r1 = 0; acc_r2 = 0;
        viol_l = 0; viol_r = 0;
        hi_l1 = -1000; hi_l2 = -1000; hi_r1 = -1000; hi_r2 = -1000;
        prv_l1 = 1'b0; prv_l2 = 1'b0; prv_r1 = 1'b0; prv_r2 = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic goto_cnt(input int c);
        @(negedge clk);
        while (ncyc % PER != c) @(negedge clk);
    endtask

    int corners[4] = '{-1024, -993, 991, 1023};

    initial begin
        int v;
        rst_n    = 1'b0;
        lft_spd  = '0;
        rght_spd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_low("reset");

        // Zero speed: 50 % duty on both channels.
        release_rst();
        repeat (3 * PER) @(negedge clk);

        // Full forward on the left, right stays at zero.
        goto_cnt(1000);
        lft_spd = 11'(1023);
        repeat (2 * PER) @(negedge clk);

        // Full reverse on the left.
        goto_cnt(1000);
        lft_spd = 11'(-1024);
        repeat (2 * PER) @(negedge clk);

        // Mid-period step only takes effect from the next period.
        goto_cnt(100);
        lft_spd = 11'(0);
        goto_cnt(500);
        goto_cnt(500);
        lft_spd = 11'(256);
        repeat (2 * PER) @(negedge clk);

        // Random speeds every 37 cycles, biased towards the mapping extremes.
        for (int i = 0; i < (15 * PER) / 37; i++) begin
            if ($urandom_range(3) == 0) v = corners[$urandom_range(3)];
            else v = int'($urandom_range(2047)) - 1024;
            lft_spd = 11'(v);
            if ($urandom_range(3) == 0) v = corners[$urandom_range(3)];
            else v = int'($urandom_range(2047)) - 1024;
            rght_spd = 11'(v);
            repeat (37) @(negedge clk);
        end

        // Asynchronous reset mid-period while PWM1 is high.
        lft_spd  = 11'(0);
        rght_spd = 11'(0);
        repeat (2 * PER) @(negedge clk);
        goto_cnt(700);
        chk("pre_reset_lftPWM1", int'(lftPWM1), 1);
        mon_en  = 1'b0;
        lft_spd = 11'(300);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_low("async_reset");
        release_rst();
        repeat (2 * PER) @(negedge clk);
        goto_cnt(1000);
        #1;
        chk("queue_residue", exp_q.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
